// File: rtl/delta_pkg.sv
// Shared types and constants for the streaming delta decoder.
package delta_pkg;

  localparam int unsigned DeltaW = 5;
  localparam int unsigned AccW   = 8;

  // Saturation limits for an AccW-bit two's-complement sample.
  localparam logic signed [AccW-1:0] SatMax = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {1'b1, {(AccW-1){1'b0}}};

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [AccW-1:0] data;
    logic            sat;
  } beat_t;

endpackage

// File: rtl/delta_sat_add.sv
// Combinational signed sign-extend, add and clip. With load_i set the delta is
// passed through sign-extended (seed), never flagged as saturated.
module delta_sat_add
  import delta_pkg::*;
#(
  parameter int unsigned DELTA_W = DeltaW,
  parameter int unsigned ACC_W   = AccW
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [DELTA_W-1:0] delta_i,
  input  logic               load_i,
  output logic [ACC_W-1:0]   sum_o,
  output logic               sat_o
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] delta_ext;
  logic [ACC_W:0] sum_wide;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    acc_ext   = {acc_i[ACC_W-1], acc_i};
    delta_ext = {{(ACC_W + 1 - DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
    sum_wide  = acc_ext + delta_ext;
    sum_o     = sum_wide[ACC_W-1:0];
    sat_o     = 1'b0;
    if (load_i) begin
      sum_o = delta_ext[ACC_W-1:0];
    end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      // Clip toward the true sign: most positive or most negative value.
      sat_o = 1'b1;
      sum_o = {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}};
    end
  end

endmodule

// File: rtl/delta_decoder.sv
// Streaming signed delta decoder: integrates deltas into absolute samples with
// saturation, behind valid/ready handshakes and a 2-entry skid buffer.
// The accumulator advances at accept time, so backpressure never changes results.
module delta_decoder
  import delta_pkg::*;
#(
  parameter int unsigned DELTA_W = DeltaW,
  parameter int unsigned ACC_W   = AccW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DELTA_W-1:0] in_delta,
  input  logic               in_restart,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

  // The beat struct is sized by the package width; reject mismatched builds.
  if (ACC_W != AccW || ACC_W < DELTA_W + 1) begin : g_bad_param
    $error("delta_decoder: ACC_W must equal delta_pkg::AccW and be >= DELTA_W+1");
  end

  buf_state_e       state_q, state_d;
  beat_t            out_q, out_d;
  beat_t            skid_q, skid_d;
  beat_t            new_beat;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic             sum_sat;
  logic             accept;
  logic             xfer;

  delta_sat_add #(
    .DELTA_W (DELTA_W),
    .ACC_W   (ACC_W)
  ) u_sat_add (
    .acc_i   (acc_q),
    .delta_i (in_delta),
    .load_i  (in_restart),
    .sum_o   (sum),
    .sat_o   (sum_sat)
  );

  // Handshake flags and outputs decode straight from registered state.
  always_comb begin
    in_ready      = (state_q != StTwo);
    out_valid     = (state_q != StEmpty);
    out_data      = out_q.data;
    out_sat       = out_q.sat;
    accept        = in_valid & in_ready;
    xfer          = out_valid & out_ready;
    new_beat.data = sum;
    new_beat.sat  = sum_sat;
  end

  // Next-state for the skid FSM, buffer entries and accumulator.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    acc_d   = accept ? sum : acc_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_d   = new_beat;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          out_d = new_beat;
        end else if (accept) begin
          skid_d  = new_beat;
          state_d = StTwo;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers; reset discards any buffered beats immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Self-checking bench for delta_decoder (DELTA_W=5, ACC_W=8): directed scenarios
// plus randomized traffic against an integer reference model.
module tb_delta_decoder;

  localparam int MaxV = 127;
  localparam int MinV = -128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] in_delta = '0;
  logic       in_restart = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int val;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc = 0;

  // Per-cycle samples taken by tick().
  bit   s_rdy, s_vld, s_acc, s_xfer, s_sat, s_have_exp;
  int   s_data;
  exp_t s_exp;

  always #5 clk = ~clk;

  delta_decoder #(
    .DELTA_W (5),
    .ACC_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_delta   (in_delta),
    .in_restart (in_restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Reference: plain integer accumulate-and-clip, evaluated when a beat is accepted.
  task automatic model_accept(input logic [4:0] d, input logic r);
    int   v;
    exp_t e;
    v = $signed(d);
    e.sat = 1'b0;
    if (r) begin
      e.val = v;
    end else begin
      e.val = m_acc + v;
      if (e.val > MaxV) begin
        e.val = MaxV;
        e.sat = 1'b1;
      end else if (e.val < MinV) begin
        e.val = MinV;
        e.sat = 1'b1;
      end
    end
    m_acc = e.val;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_acc = 0;
    exp_q.delete();
  endtask

  // Sample outputs in the low phase, update the model, then advance one cycle.
  task automatic tick();
    #1;
    s_rdy  = in_ready;
    s_vld  = out_valid;
    s_data = $signed(out_data);
    s_sat  = out_sat;
    s_acc  = in_valid & in_ready;
    s_xfer = out_valid & out_ready;
    s_have_exp = 1'b0;
    if (s_xfer && exp_q.size() > 0) begin
      s_exp = exp_q.pop_front();
      s_have_exp = 1'b1;
    end
    if (s_acc) model_accept(in_delta, in_restart);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_data !== 8'd0 || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d/%b want 0/0", out_data, out_sat);
    end
    rst = 1'b1;
    model_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_restart = 1'b0; in_delta = 5'd1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (!s_xfer || s_data !== 1 || s_sat !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_delta: got v=%b %0d/%b want v=1 1/0", s_xfer, s_data,
                         s_sat);
    end
  endtask

  task automatic test_basic();
    int d[4] = '{3, 5, -2, -10};
    int e[4] = '{3, 8, 6, -4};
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_restart = (i == 0); in_delta = 5'(d[i]);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i < 4) begin
        n_cmp++;
        if (!s_acc) begin
          n_fail++; $display("FAIL basic_accept[%0d]: got 0 want 1", i);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (!s_vld || s_data !== e[i-1] || s_sat !== 1'b0) begin
          n_fail++; $display("FAIL basic_out[%0d]: got v=%b %0d/%b want v=1 %0d/0", i - 1, s_vld,
                             s_data, s_sat, e[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int d[19] = '{15, 15, 15, 15, 15, 15, 15, 15, 15, -16,
                  -16, -16, -16, -16, -16, -16, -16, -16, -1};
    int e[19] = '{15, 30, 45, 60, 75, 90, 105, 120, 127, 111,
                  -16, -32, -48, -64, -80, -96, -112, -128, -128};
    bit s[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    out_ready = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      if (i < 19) begin
        in_valid = 1'b1; in_restart = (i == 0 || i == 10); in_delta = 5'(d[i]);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i > 0) begin
        n_cmp++;
        if (!s_vld || s_data !== e[i-1] || s_sat !== s[i-1]) begin
          n_fail++; $display("FAIL sat_out[%0d]: got v=%b %0d/%b want v=1 %0d/%b", i - 1, s_vld,
                             s_data, s_sat, e[i-1], s[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    bit pend;
    out_ready = 1'b0;
    in_valid = 1'b1; in_restart = 1'b1; in_delta = 5'd1;
    tick();
    n_cmp++;
    if (!s_acc) begin
      n_fail++; $display("FAIL bp_accept1: got 0 want 1");
    end
    in_restart = 1'b0; in_delta = 5'd1;
    tick();
    n_cmp++;
    if (!s_acc) begin
      n_fail++; $display("FAIL bp_accept2: got 0 want 1");
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (s_rdy !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready_low[%0d]: got %b want 0", c, s_rdy);
      end
      n_cmp++;
      if (!s_vld || s_data !== 1 || s_sat !== 1'b0) begin
        n_fail++; $display("FAIL bp_stable[%0d]: got v=%b %0d want v=1 1", c, s_vld, s_data);
      end
    end
    out_ready = 1'b1;
    nxt = 1;
    pend = 1'b1;
    for (int c = 0; c < 8 && nxt <= 3; c++) begin
      if (!pend) in_valid = 1'b0;
      tick();
      if (s_acc) pend = 1'b0;
      if (s_xfer) begin
        n_cmp++;
        if (s_data !== nxt) begin
          n_fail++; $display("FAIL bp_order: got %0d want %0d", s_data, nxt);
        end
        nxt++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (nxt != 4) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d want 3", nxt - 1);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_restart = 1'b1; in_delta = 5'($urandom);
    tick();
    for (int c = 0; c < 10; c++) begin
      in_restart = 1'b0; in_delta = 5'($urandom);
      tick();
      n_cmp++;
      if (!s_rdy || !s_xfer) begin
        n_fail++; $display("FAIL b2b_throughput[%0d]: got rdy=%b xfer=%b want 1/1", c, s_rdy,
                           s_xfer);
      end
      n_cmp++;
      if (!s_have_exp || s_data !== s_exp.val || s_sat !== s_exp.sat) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %0d/%b want %0d/%b", c, s_data, s_sat,
                           s_exp.val, s_exp.sat);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (!s_have_exp || s_data !== s_exp.val || s_sat !== s_exp.sat) begin
      n_fail++; $display("FAIL b2b_last: got %0d/%b want %0d/%b", s_data, s_sat, s_exp.val,
                         s_exp.sat);
    end
  endtask

  task automatic test_random();
    bit prev_stall = 1'b0;
    int prev_data = 0;
    bit prev_sat = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_restart = ($urandom_range(0, 15) == 0);
      in_delta = in_valid ? 5'($urandom) : 5'bx;
      tick();
      if (prev_stall) begin
        n_cmp++;
        if (!s_vld || s_data !== prev_data || s_sat !== prev_sat) begin
          n_fail++; $display("FAIL rand_hold[%0d]: got v=%b %0d/%b want v=1 %0d/%b", c, s_vld,
                             s_data, s_sat, prev_data, prev_sat);
        end
      end
      if (s_xfer) begin
        n_cmp++;
        if (!s_have_exp || s_data !== s_exp.val || s_sat !== s_exp.sat) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %0d/%b want %0d/%b (model had=%b)", c,
                             s_data, s_sat, s_exp.val, s_exp.sat, s_have_exp);
        end
      end
      prev_stall = s_vld && !s_xfer;
      prev_data = s_data;
      prev_sat = s_sat;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (s_xfer) begin
        n_cmp++;
        if (!s_have_exp || s_data !== s_exp.val || s_sat !== s_exp.sat) begin
          n_fail++; $display("FAIL rand_drain: got %0d/%b want %0d/%b", s_data, s_sat,
                             s_exp.val, s_exp.sat);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_empty: got pending=%0d valid=%b want 0/0", exp_q.size(),
                         out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_restart = 1'b1; in_delta = 5'd9;
    tick();
    in_restart = 1'b0; in_delta = 5'd2;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pre: got v=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: got v=%b d=%0d s=%b rdy=%b want 0/0/0/1", out_valid,
                         out_data, out_sat, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_restart = 1'b0; in_delta = 5'd4;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (!s_xfer || s_data !== 4 || s_sat !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got v=%b %0d/%b want v=1 4/0", s_xfer, s_data, s_sat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_decoder.md
Name: delta_decoder

Overview:
- Streaming signed delta decoder: integrates a stream of signed deltas back into absolute signed samples. It is the receive-side inverse of the delta encoder, which produces each delta as a signed difference using the same signed-arithmetic rules as our combinational adder modules.
- Sits between a narrow signed delta source and a wide sample consumer.
- Valid/ready on both sides, 2-entry skid buffering, saturating accumulation.

Parameters:
- DELTA_W, 5, width of the signed input delta.
- ACC_W, 8, width of the signed accumulator and output sample; must be >= DELTA_W+1.

Ports:
- clk  input  1  the block's one clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_delta  input  DELTA_W  signed delta, or absolute seed when in_restart=1.
- in_restart  input  1  qualifies the beat as a seed: accumulator is loaded, not added.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat; registered, no combinational path from out_ready.
- out_data  output  ACC_W  signed reconstructed sample.
- out_sat  output  1  this sample was clipped by saturation.
- out_valid  output  1  out_data/out_sat valid.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset (rst low, asynchronous): acc=0, state=EMPTY, out_valid=0, out_data=0, out_sat=0, in_ready=1. Takes effect immediately, mid-transfer included. Buffered beats are discarded.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Per accepted beat:
  - If in_restart=1: next = sign-extend(in_delta), sat=0.
  - Otherwise: next = sat(acc + sign-extend(in_delta)), computed at ACC_W+1 bits. Clip to +2^(ACC_W-1)-1 or -2^(ACC_W-1), with sat=1 only when clipping occurred.
  - acc <= next on the same edge. Exact boundary results (e.g. -128 for ACC_W=8) are not saturation.
- Latency: an accepted beat appears on out_data on the next cycle when the output stage is free.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1, skid free.
    - Accept & transfer -> ONE; the new beat goes to the output stage. Full throughput: 1 beat/cycle.
    - Accept only -> TWO; the new beat goes to skid.
    - Transfer only -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Transfer -> ONE; skid moves to the output stage.
    - in_valid is ignored while in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- The accumulator advances at accept time, not at drain time. Backpressure therefore never alters the arithmetic.
- X on in_delta while in_valid=0 must not affect state.

Decomposition:
- Package delta_pkg:
  - buffer state enum {EMPTY, ONE, TWO}.
  - Saturation limit constants derived from ACC_W.
  - Beat struct {data, sat}.
- One sub-module, delta_sat_add: purely combinational signed sign-extend + add + clip, outputs {sum, sat}. It is reused by the delta encoder team for its subtract-and-clip path.
- The FSM and skid buffer stay in delta_decoder.

Test Plan (DELTA_W=5, ACC_W=8):
- Reset: hold rst low, then release -> out_valid=0, in_ready=1, out_data=0. Restart-free delta +1 then gives out_data=1.
- Basic: out_ready=1; seed 3, then deltas +5, -2, -10 -> out_data 3, 8, 6, -4 on consecutive cycles, each one cycle after accept; out_sat=0 throughout.
- Saturation:
  - Seed 15, then +15 x8 -> 30 … 120, then 127 with out_sat=1. Then -16 -> 111, out_sat=0.
  - Seed -16, then -16 x7 -> reaches -128 exactly with out_sat=0. Then -1 -> -128, out_sat=1.
- Backpressure: out_ready=0, send seed 1, +1, +1 -> in_ready falls after the 2nd accept; the 3rd beat is held by the source. Raise out_ready -> outputs 1, 2, 3 in order; out_data stable while stalled.
- Simultaneous: in state ONE with in_valid=1 and out_ready=1 for 10 cycles -> 10 outputs in 10 cycles; in_ready never drops.
- Reset mid-operation: in TWO, pull rst low between edges -> out_valid and out_data clear without a clock edge. After release, delta +4 -> out_data=4.
